// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: select codes and default latencies.
package md_unit_pkg;

  // Operation select codes carried down the pipeline with the instruction.
  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_sel_e;

  // Default busy lengths for the two long-latency operation classes.
  localparam int MD_MULT_CYC = 5;
  localparam int MD_DIV_CYC  = 10;

endpackage

// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: computes mult/div results up front,
// holds them privately for a fixed latency, then commits them to HI/LO.
// Handshake: there is no valid/ready pair; an md op is accepted in the cycle
// its select is present and busy is low, and md_stall = start | busy tells the
// stall unit to hold the following md-class instruction until busy falls.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYC,
  parameter int DIV_CYCLES  = MD_DIV_CYC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  input  logic [3:0]  md_sel,
  output logic        md_stall,
  output logic        busy,
  output logic [31:0] md_out
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  logic          is_mult, is_div, signed_op, start, div_zero;
  logic [31:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
  logic [63:0]   prod_mag, prod;

  // Decode the select and do the arithmetic on sign-corrected magnitudes.
  always_comb begin
    is_mult   = (md_sel == MD_MULT) || (md_sel == MD_MULTU);
    is_div    = (md_sel == MD_DIV)  || (md_sel == MD_DIVU);
    signed_op = (md_sel == MD_MULT) || (md_sel == MD_DIV);
    start     = (is_mult || is_div) && !busy_q;
    div_zero  = (d2 == 32'd0);

    a_mag     = (signed_op && d1[31]) ? (32'd0 - d1) : d1;
    b_mag     = (signed_op && d2[31]) ? (32'd0 - d2) : d2;

    prod_mag  = {32'd0, a_mag} * {32'd0, b_mag};
    prod      = (signed_op && (d1[31] ^ d2[31])) ? (64'd0 - prod_mag) : prod_mag;

    // Divisor is forced non-zero so the divider never sees x/0; the result is dropped anyway.
    b_safe    = div_zero ? 32'd1 : b_mag;
    q_mag     = a_mag / b_safe;
    r_mag     = a_mag % b_safe;
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    quot      = (signed_op && (d1[31] ^ d2[31])) ? (32'd0 - q_mag) : q_mag;
    rem       = (signed_op && d1[31]) ? (32'd0 - r_mag) : r_mag;
  end

  // Next-state: start loads the pending result and counter, busy counts down to commit.
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      busy_d = 1'b1;
      if (is_mult) begin
        cnt_d              = CW'(MULT_CYCLES);
        {hi_tmp_d, lo_tmp_d} = prod;
      end else begin
        cnt_d = CW'(DIV_CYCLES);
        // Divide by zero commits the current HI/LO back, leaving them unchanged.
        if (div_zero) begin
          hi_tmp_d = hi_q;
          lo_tmp_d = lo_q;
        end else begin
          hi_tmp_d = rem;
          lo_tmp_d = quot;
        end
      end
    end else if (busy_q) begin
      if (cnt_q == CW'(1)) begin
        hi_d   = hi_tmp_q;
        lo_d   = lo_tmp_q;
        cnt_d  = '0;
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end else begin
      if (md_sel == MD_MTHI) hi_d = d1;
      if (md_sel == MD_MTLO) lo_d = d1;
    end
  end

  // State registers with synchronous reset; reset discards any in-flight result.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  // Architectural read port; only committed HI/LO are ever visible.
  always_comb begin
    md_out = 32'd0;
    if (md_sel == MD_MFHI) md_out = hi_q;
    if (md_sel == MD_MFLO) md_out = lo_q;
  end

  assign busy     = busy_q;
  assign md_stall = start || busy_q;

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the E stage of the five-stage pipeline. It takes the forwarded rs/rt operands and a decoded operation select, models fixed multi-cycle mult/div latency with a busy counter, and holds the architectural HI/LO registers. It drives `md_out` into the E→M pipeline register and `md_stall` into the stall unit, which freezes D/F and bubbles E while an md-class instruction waits in D.

## Interface

Parameters:

- `MULT_CYCLES`, 5: busy cycles for mult/multu (≥1).
- `DIV_CYCLES`, 10: busy cycles for div/divu (≥1).

Ports:

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `d1` input 32: forwarded rs value (E stage).
- `d2` input 32: forwarded rt value (E stage).
- `md_sel` input 4: operation select; codes from `const.v`.
- `md_stall` output 1: `start | busy`; consumed by the stall unit.
- `busy` output 1: registered; high while an operation is in flight.
- `md_out` output 32: HI for `md_mfhi`, LO for `md_mflo`, else 0.

## Operation

- `md_sel` codes:
  - 0 `md_none`
  - 1 `md_mult`
  - 2 `md_multu`
  - 3 `md_div`
  - 4 `md_divu`
  - 5 `md_mfhi`
  - 6 `md_mflo`
  - 7 `md_mthi`
  - 8 `md_mtlo`
  - 9–15 are treated as `md_none`.
- `start` is combinational: high when `md_sel` is 1–4 and `busy` is 0.
- On `start`:
  - Compute the result from `d1`/`d2` into internal `hi_tmp`/`lo_tmp`.
  - Load the counter with `MULT_CYCLES` or `DIV_CYCLES`.
  - Set `busy`.
- While `busy`: decrement the counter each cycle. When it reaches 1:
  - Commit `hi_tmp`/`lo_tmp` to HI/LO on that edge.
  - Clear `busy`.
- mult: {HI,LO} = signed 64-bit product.
- multu: {HI,LO} = unsigned 64-bit product.
- div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder.
- Divide by zero (`d2`==0): the op still occupies `DIV_CYCLES` cycles, and HI/LO are left unchanged.
- mthi / mtlo: HI or LO ← `d1` on the same edge. No busy phase, no stall contribution.
  - Ignored while `busy`; the stall unit guarantees this cannot happen.
- mult/div arriving while `busy` is ignored. Verification carries an assertion that this never occurs.
- mfhi / mflo read the architectural HI/LO combinationally. Uncommitted `hi_tmp`/`lo_tmp` are never visible.
- Reset, including mid-operation:
  - HI, LO, `hi_tmp`, `lo_tmp`, counter ← 0; `busy` ← 0.
  - The in-flight result is discarded.

## Timing

- Reset values:
  - `busy` = 0.
  - `md_stall` = `start` (0 when `md_sel` is none).
  - `md_out` = 0 for all selects, since HI = LO = 0.
- For a mult issued in E at cycle T:
  - `md_stall` is high T..T+5.
  - `busy` is high T+1..T+5.
  - HI/LO update at the end of T+5.
  - An mfhi entering E at T+6 reads the new value.
- Div latency is the same, with 10 in place of 5.
- Back-to-back: a second mult can start in the cycle `busy` falls (T+6).
- mthi followed directly by mfhi: the value written at the end of cycle T is read in T+1 (zero-bubble).
- A select is acted on only in the cycle it is present. Bubbles from E reset present `md_none`.

## Structure

- `const.v` holds:
  - the `md_*` select codes (4-bit);
  - default cycle counts `md_mult_cyc` = 5 and `md_div_cyc` = 10, which feed the parameters.
- Single module with behavioural `*`, `/`, `%` on sign-corrected operands. No sub-module.
- Counter width is `$clog2(max(MULT_CYCLES,DIV_CYCLES)+1)`.

## Test plan

- **Signed multiply:** mult `d1`=0xFFFFFFFE (−2), `d2`=3 → `md_stall` is 1 for 6 cycles. Then mfhi = 0xFFFFFFFF and mflo = 0xFFFFFFFA.
- **Unsigned multiply:** multu 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001, committed exactly 5 cycles after start.
- **Signed divide:** div −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- **Overflow and divide by zero:**
  - div 0x80000000 / −1 → LO = 0x80000000, HI = 0.
  - divu 5 / 0 → `busy` for 10 cycles, HI/LO unchanged.
- **Move-to then move-from:** mthi 0x12345678, next cycle mfhi → `md_out` = 0x12345678 with `md_stall` = 0 throughout. Same check for mtlo/mflo.
- **Reset mid-operation:** start div 100/7, assert `reset` at the 4th busy cycle → next cycle `busy` = 0, HI = LO = 0. A following mflo returns 0, not 14.
